display_spi_arbiter: RTL and testbench
======================================

DISPLAY_SPI_ARBITER -- requirements
Module: display_spi_arbiter

Interface
REQ-001 Parameter GUARD_CYCLES, default 1: idle cycles after each issued command before `dspi_ready` is sampled again (legal range 1..15).
REQ-002 Parameter BURST_TIMEOUT, default 1023: cycles a locked owner may go without `valid` before its lock is revoked (legal range 1..1023).
REQ-003 `clk`  in  1  single clock; every flop is rising-edge.
REQ-004 `rst_n`  in  1  reset; asynchronous assert, active-low.
REQ-005 `r0_valid`  in  1  requester 0 has a command byte pending.
REQ-006 `r0_cmd`  in  2  requester 0 code: 00 NONE, 01 RESET, 10 SEND_COMMAND, 11 SEND_DATA.
REQ-007 `r0_byte`  in  8  requester 0 payload byte.
REQ-008 `r0_last`  in  1  this byte ends requester 0's atomic sequence.
REQ-009 `r0_accept`  out  1  one-cycle pulse when requester 0's current item is consumed.
REQ-010 `r1_valid`, `r1_cmd`, `r1_byte`, `r1_last`, `r1_accept` SHALL match REQ-005..009 for requester 1.
REQ-011 `dspi_ready`  in  1  the SPI engine is idle and able to take a command.
REQ-012 `dspi_cmd`  out  3  command to the SPI engine; bit 2 is always 0; 000 means none.
REQ-013 `dspi_byte`  out  8  payload accompanying `dspi_cmd`.
REQ-014 `grant`  out  2  one-hot current owner; 00 when no requester holds the lock.
REQ-015 `timeout_flag`  out  1  one-cycle pulse when a lock is revoked by timeout.

Function
REQ-016 States: IDLE (no owner), OWNED (owner locked, waiting), ISSUE (command driven), GUARD (post-issue wait).
REQ-017 IDLE: when any `rN_valid`=1 and `dspi_ready`=1 in cycle T, the winner is chosen, `grant` is set, the winner's cmd/byte are registered, and the state becomes ISSUE at T+1.
REQ-018 Arbitration: if both requesters are valid, the requester indicated by the round-robin pointer wins.
REQ-019 Round-robin pointer: it points to the non-winner after every released lock (last byte, RESET, or timeout).
REQ-020 ISSUE lasts exactly one cycle; `dspi_cmd`/`dspi_byte` carry the registered item and the owner's `rN_accept` is 1 in that same cycle.
REQ-021 Outside ISSUE, `dspi_cmd` SHALL be 000 and both accept outputs SHALL be 0.
REQ-022 An item with cmd NONE is consumed: accept pulses and `last` is honoured, but `dspi_cmd` stays 000.
REQ-023 Requesters hold valid/cmd/byte/last stable until accept; they may present the next item in the cycle after accept.
REQ-024 GUARD lasts GUARD_CYCLES cycles and ignores `dspi_ready`, covering the engine's ready-drop latency.
REQ-025 GUARD exit when the consumed item had `last`=1 or cmd RESET (RESET is always treated as last): go to IDLE, `grant`=00, pointer updated.
REQ-026 GUARD exit otherwise: go to OWNED.
REQ-027 OWNED: when owner `valid`=1 and `dspi_ready`=1 in cycle T, the item is registered and the state is ISSUE at T+1; the other requester is never accepted.
REQ-028 OWNED idle counter: 10-bit, counts OWNED cycles with owner `valid`=0, and clears on owner `valid`=1.
REQ-029 OWNED timeout: when the counter reaches BURST_TIMEOUT, go to IDLE with `grant`=00, pulse `timeout_flag` for one cycle, and update the pointer.
REQ-030 Lowering `valid` while in OWNED does not release the lock; only last, RESET, or timeout release it.
REQ-031 `dspi_ready`=0 stalls IDLE and OWNED indefinitely; it does not advance the timeout counter unless owner `valid`=0.
REQ-032 Issue rate: at most one command per 2+GUARD_CYCLES cycles.

Reset
REQ-033 While `rst_n`=0, all outputs are forced immediately: `dspi_cmd`=000, `dspi_byte`=00, accepts=0, `grant`=00, `timeout_flag`=0, state IDLE, pointer=requester 0, counter=0.
REQ-034 Reset asserted mid-sequence drops the lock with no further issue; after release, operation begins with IDLE arbitration on the first edge where `dspi_ready`=1.

Verification
REQ-035 Bench scenario, simultaneous request after reset: r0 and r1 both valid with SEND_COMMAND 0xAE, last=1, `dspi_ready`=1 -> r0 issued first (`dspi_cmd`=010, `dspi_byte`=AE), then r1 after its guard.
REQ-036 Bench scenario, atomic sequence: r0 sends 3 bytes 0x21, 0x00, 0x7F (last on the third) while r1 is continuously valid -> three consecutive r0 issues, then r1; `grant`=01 throughout r0's sequence.
REQ-037 Bench scenario, timeout: BURST_TIMEOUT=8; r1 sends one byte with last=0, then drops valid -> `timeout_flag` pulses exactly 8 cycles after entering OWNED, `grant`=00, and r0 is served next.
REQ-038 Bench scenario, ready stall: `dspi_ready` held at 0 for 50 cycles with r0 valid -> no accept and `dspi_cmd`=000; issue occurs 1 cycle after `dspi_ready` rises.
REQ-039 Bench scenario, RESET and NONE: r1 issues RESET with last=0 -> `dspi_cmd`=001 and the lock is released; r0 item with cmd NONE -> `r0_accept` pulses while `dspi_cmd` stays 000.
REQ-040 Bench scenario, mid-issue reset: `rst_n` pulled low during ISSUE -> `dspi_cmd`=000 in the same cycle without waiting for `clk`, `grant`=00, and after release r0 wins the next tie.

Source files
------------

// File: rtl/display_spi_arbiter.sv
// Two-requester arbiter in front of a display SPI engine: locks one owner for an
// atomic byte sequence, paces issues with a guard window and revokes idle locks.
module display_spi_arbiter #(
    parameter int unsigned GUARD_CYCLES  = 1,
    parameter int unsigned BURST_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       r0_valid,
    input  logic [1:0] r0_cmd,
    input  logic [7:0] r0_byte,
    input  logic       r0_last,
    output logic       r0_accept,
    input  logic       r1_valid,
    input  logic [1:0] r1_cmd,
    input  logic [7:0] r1_byte,
    input  logic       r1_last,
    output logic       r1_accept,
    input  logic       dspi_ready,
    output logic [2:0] dspi_cmd,
    output logic [7:0] dspi_byte,
    output logic [1:0] grant,
    output logic       timeout_flag
);

    localparam logic [1:0] CMD_RESET      = 2'b01;
    localparam logic [3:0] GUARD_LAST_C   = 4'(GUARD_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_LAST_C = 10'(BURST_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWNED = 2'b01,
        ST_ISSUE = 2'b10,
        ST_GUARD = 2'b11
    } state_t;

    state_t     state_r;
    logic       owner_r;
    logic       ptr_r;
    logic       release_r;
    logic [3:0] guard_cnt_r;
    logic [9:0] idle_cnt_r;

    logic       win_s;
    logic       sel_s;
    logic       sel_valid_s;
    logic       sel_last_s;
    logic [1:0] sel_cmd_s;
    logic [7:0] sel_byte_s;

    function automatic logic [1:0] onehot(input logic idx);
        if (idx) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    // Select the candidate item: tie-break winner in IDLE, locked owner otherwise.
    always_comb begin
        win_s       = 1'b0;
        sel_s       = 1'b0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_cmd_s   = 2'b00;
        sel_byte_s  = 8'h00;
        if (r0_valid && r1_valid) begin
            win_s = ptr_r;
        end else if (r1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if (state_r == ST_IDLE) begin
            sel_s = win_s;
        end else begin
            sel_s = owner_r;
        end
        if (sel_s) begin
            sel_valid_s = r1_valid;
            sel_last_s  = r1_last;
            sel_cmd_s   = r1_cmd;
            sel_byte_s  = r1_byte;
        end else begin
            sel_valid_s = r0_valid;
            sel_last_s  = r0_last;
            sel_cmd_s   = r0_cmd;
            sel_byte_s  = r0_byte;
        end
    end

    // Arbitration FSM with all engine-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            ptr_r        <= 1'b0;
            release_r    <= 1'b0;
            guard_cnt_r  <= 4'd0;
            idle_cnt_r   <= 10'd0;
            r0_accept    <= 1'b0;
            r1_accept    <= 1'b0;
            dspi_cmd     <= 3'b000;
            dspi_byte    <= 8'h00;
            grant        <= 2'b00;
            timeout_flag <= 1'b0;
        end else begin
            r0_accept    <= 1'b0;
            r1_accept    <= 1'b0;
            dspi_cmd     <= 3'b000;
            dspi_byte    <= 8'h00;
            timeout_flag <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s && dspi_ready) begin
                        owner_r   <= sel_s;
                        grant     <= onehot(sel_s);
                        dspi_cmd  <= {1'b0, sel_cmd_s};
                        dspi_byte <= sel_byte_s;
                        r0_accept <= ~sel_s;
                        r1_accept <= sel_s;
                        release_r <= sel_last_s || (sel_cmd_s == CMD_RESET);
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_OWNED: begin
                    if (sel_valid_s) begin
                        idle_cnt_r <= 10'd0;
                        if (dspi_ready) begin
                            dspi_cmd  <= {1'b0, sel_cmd_s};
                            dspi_byte <= sel_byte_s;
                            r0_accept <= ~owner_r;
                            r1_accept <= owner_r;
                            release_r <= sel_last_s || (sel_cmd_s == CMD_RESET);
                            state_r   <= ST_ISSUE;
                        end
                    end else if (idle_cnt_r == TIMEOUT_LAST_C) begin
                        // Owner went quiet too long: drop the lock and hand priority over.
                        idle_cnt_r   <= 10'd0;
                        timeout_flag <= 1'b1;
                        grant        <= 2'b00;
                        ptr_r        <= ~owner_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + 10'd1;
                    end
                end
                ST_ISSUE: begin
                    guard_cnt_r <= 4'd0;
                    state_r     <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_cnt_r == GUARD_LAST_C) begin
                        if (release_r) begin
                            grant   <= 2'b00;
                            ptr_r   <= ~owner_r;
                            state_r <= ST_IDLE;
                        end else begin
                            idle_cnt_r <= 10'd0;
                            state_r    <= ST_OWNED;
                        end
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 4'd1;
                    end
                end
                default: begin
                    grant   <= 2'b00;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_spi_arbiter.sv
// Directed bench for display_spi_arbiter (GUARD_CYCLES=2, BURST_TIMEOUT=8);
// outputs are sampled 1 time unit after each rising edge.
module tb_display_spi_arbiter;

    logic       clk;
    logic       rst_n;
    logic       r0_valid, r1_valid;
    logic [1:0] r0_cmd, r1_cmd;
    logic [7:0] r0_byte, r1_byte;
    logic       r0_last, r1_last;
    logic       r0_accept, r1_accept;
    logic       dspi_ready;
    logic [2:0] dspi_cmd;
    logic [7:0] dspi_byte;
    logic [1:0] grant;
    logic       timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    display_spi_arbiter #(
        .GUARD_CYCLES (2),
        .BURST_TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r0_valid    (r0_valid),
        .r0_cmd      (r0_cmd),
        .r0_byte     (r0_byte),
        .r0_last     (r0_last),
        .r0_accept   (r0_accept),
        .r1_valid    (r1_valid),
        .r1_cmd      (r1_cmd),
        .r1_byte     (r1_byte),
        .r1_last     (r1_last),
        .r1_accept   (r1_accept),
        .dspi_ready  (dspi_ready),
        .dspi_cmd    (dspi_cmd),
        .dspi_byte   (dspi_byte),
        .grant       (grant),
        .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input string tag, input logic [2:0] cmd, input logic [7:0] b,
                                input logic a0, input logic a1, input logic [1:0] g);
        chk({tag, "_cmd"}, 32'(dspi_cmd), 32'(cmd));
        chk({tag, "_byte"}, 32'(dspi_byte), 32'(b));
        chk({tag, "_acc0"}, 32'(r0_accept), 32'(a0));
        chk({tag, "_acc1"}, 32'(r1_accept), 32'(a1));
        chk({tag, "_grant"}, 32'(grant), 32'(g));
    endtask

    task automatic expect_quiet(input string tag, input logic [1:0] g);
        chk({tag, "_cmd"}, 32'(dspi_cmd), 32'(3'b000));
        chk({tag, "_acc0"}, 32'(r0_accept), 32'(1'b0));
        chk({tag, "_acc1"}, 32'(r1_accept), 32'(1'b0));
        chk({tag, "_grant"}, 32'(grant), 32'(g));
    endtask

    initial begin
        rst_n = 1'b0; dspi_ready = 1'b0;
        r0_valid = 1'b0; r0_cmd = 2'b00; r0_byte = 8'h00; r0_last = 1'b0;
        r1_valid = 1'b0; r1_cmd = 2'b00; r1_byte = 8'h00; r1_last = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_issue("rst", 3'b000, 8'h00, 1'b0, 1'b0, 2'b00);
        chk("rst_tflag", 32'(timeout_flag), 32'(1'b0));
        rst_n = 1'b1; dspi_ready = 1'b1;

        // Simultaneous request: r0 first, r1 after guard
        r0_valid = 1'b1; r0_cmd = 2'b10; r0_byte = 8'hAE; r0_last = 1'b1;
        r1_valid = 1'b1; r1_cmd = 2'b10; r1_byte = 8'hAE; r1_last = 1'b1;
        step(); expect_issue("s1_r0", 3'b010, 8'hAE, 1'b1, 1'b0, 2'b01);
        r0_valid = 1'b0;
        step(); expect_quiet("s1_guard_a", 2'b01);
        step(); expect_quiet("s1_guard_b", 2'b01);
        step(); expect_quiet("s1_release", 2'b00);
        step(); expect_issue("s1_r1", 3'b010, 8'hAE, 1'b0, 1'b1, 2'b10);
        r1_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s1_end", 2'b00);

        // Atomic 3-byte sequence from r0 while r1 keeps requesting
        r0_valid = 1'b1; r0_cmd = 2'b11; r0_byte = 8'h21; r0_last = 1'b0;
        r1_valid = 1'b1; r1_cmd = 2'b11; r1_byte = 8'h55; r1_last = 1'b1;
        step(); expect_issue("s2_b0", 3'b011, 8'h21, 1'b1, 1'b0, 2'b01);
        r0_byte = 8'h00;
        step(); expect_quiet("s2_g0a", 2'b01);
        step(); expect_quiet("s2_g0b", 2'b01);
        step(); expect_quiet("s2_owned0", 2'b01);
        step(); expect_issue("s2_b1", 3'b011, 8'h00, 1'b1, 1'b0, 2'b01);
        r0_byte = 8'h7F; r0_last = 1'b1;
        repeat (3) step();
        expect_quiet("s2_owned1", 2'b01);
        step(); expect_issue("s2_b2", 3'b011, 8'h7F, 1'b1, 1'b0, 2'b01);
        r0_valid = 1'b0;
        step(); expect_quiet("s2_g2a", 2'b01);
        step(); expect_quiet("s2_g2b", 2'b01);
        step(); expect_quiet("s2_release", 2'b00);
        step(); expect_issue("s2_r1", 3'b011, 8'h55, 1'b0, 1'b1, 2'b10);
        r1_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s2_end", 2'b00);

        // Timeout: r1 sends a non-last byte then goes quiet; r0 waits locked out
        r1_valid = 1'b1; r1_cmd = 2'b11; r1_byte = 8'h3C; r1_last = 1'b0;
        step(); expect_issue("s3_r1", 3'b011, 8'h3C, 1'b0, 1'b1, 2'b10);
        r1_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s3_owned", 2'b10);
        chk("s3_tflag_enter", 32'(timeout_flag), 32'(1'b0));
        r0_valid = 1'b1; r0_cmd = 2'b10; r0_byte = 8'h99; r0_last = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("s3_tflag_wait", 32'(timeout_flag), 32'(1'b0));
            chk("s3_acc0_locked", 32'(r0_accept), 32'(1'b0));
            chk("s3_grant_held", 32'(grant), 32'(2'b10));
        end
        step();
        chk("s3_tflag_pulse", 32'(timeout_flag), 32'(1'b1));
        expect_quiet("s3_revoked", 2'b00);
        step();
        chk("s3_tflag_clear", 32'(timeout_flag), 32'(1'b0));
        expect_issue("s3_r0", 3'b010, 8'h99, 1'b1, 1'b0, 2'b01);
        r0_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s3_end", 2'b00);

        // Ready stall: 50 cycles of dspi_ready=0 with r0 pending
        dspi_ready = 1'b0;
        r0_valid = 1'b1; r0_cmd = 2'b10; r0_byte = 8'h5A; r0_last = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("s4_stall_acc0", 32'(r0_accept), 32'(1'b0));
            chk("s4_stall_cmd", 32'(dspi_cmd), 32'(3'b000));
        end
        dspi_ready = 1'b1;
        step(); expect_issue("s4_r0", 3'b010, 8'h5A, 1'b1, 1'b0, 2'b01);
        r0_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s4_end", 2'b00);

        // RESET from r1 (pointer favours r1) releases the lock; r0 NONE is consumed silently
        r1_valid = 1'b1; r1_cmd = 2'b01; r1_byte = 8'h00; r1_last = 1'b0;
        r0_valid = 1'b1; r0_cmd = 2'b00; r0_byte = 8'h77; r0_last = 1'b1;
        step(); expect_issue("s5_reset", 3'b001, 8'h00, 1'b0, 1'b1, 2'b10);
        r1_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s5_released", 2'b00);
        step();
        chk("s5_none_cmd", 32'(dspi_cmd), 32'(3'b000));
        chk("s5_none_acc0", 32'(r0_accept), 32'(1'b1));
        chk("s5_none_acc1", 32'(r1_accept), 32'(1'b0));
        chk("s5_none_grant", 32'(grant), 32'(2'b01));
        r0_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s5_end", 2'b00);

        // Mid-issue reset: r1 wins the tie, reset drops it asynchronously, r0 wins afterwards
        r0_valid = 1'b1; r0_cmd = 2'b10; r0_byte = 8'hAE; r0_last = 1'b1;
        r1_valid = 1'b1; r1_cmd = 2'b10; r1_byte = 8'hAE; r1_last = 1'b1;
        step(); expect_issue("s6_r1", 3'b010, 8'hAE, 1'b0, 1'b1, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        expect_issue("s6_async", 3'b000, 8'h00, 1'b0, 1'b0, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(); expect_issue("s6_r0", 3'b010, 8'hAE, 1'b1, 1'b0, 2'b01);
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (3) step();
        expect_quiet("s6_end", 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
